// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if: AXI4-Lite-subset bundle between a core master and the SRAM responder
interface axi_if;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  modport slave (
    input  araddr, arsize, arvalid, rready, awaddr, awsize, awvalid,
           wdata, wstrb, wlast, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
  modport master (
    output araddr, arsize, arvalid, rready, awaddr, awsize, awvalid,
           wdata, wstrb, wlast, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-outstanding AXI4-Lite SRAM responder with fixed latency and DECERR window
module axi_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          R_LATENCY   = 2,
  parameter int          W_LATENCY   = 2
) (
  input logic  clk,
  input logic  rst,
  axi_if.slave axiif
);
  localparam int AW   = $clog2(DEPTH_WORDS);
  localparam int MAXL = (R_LATENCY > W_LATENCY) ? R_LATENCY : W_LATENCY;
  localparam int CW   = $clog2(MAXL) + 1;
  typedef enum logic [2:0] {IDLE, WCOLLECT, RDELAY, RRESP, WDELAY, BRESP} state_t;
  state_t          state;
  logic            prefer_write, have_aw, have_w;
  logic [CW-1:0]   cnt;
  logic [31:0]     addr, wdata;
  logic [3:0]      wstrb;
  logic [31:0]     mem [DEPTH_WORDS];
  logic            rd_req, wr_req, grant_rd, grant_wr, ar_hs, aw_hs, w_hs, wr_both, hit, commit;
  logic [31:0]     off;
  logic [AW-1:0]   idx;
  logic            unused;
  assign rd_req   = axiif.arvalid;
  assign wr_req   = axiif.awvalid | axiif.wvalid;
  assign grant_wr = wr_req & (~rd_req | prefer_write);
  assign grant_rd = rd_req & ~grant_wr;
  assign axiif.arready = ~rst & (state == IDLE) & ~grant_wr;
  assign axiif.awready = ~rst & ((state == IDLE) ? ~grant_rd : (state == WCOLLECT) & ~have_aw);
  assign axiif.wready  = ~rst & ((state == IDLE) ? ~grant_rd : (state == WCOLLECT) & ~have_w);
  assign ar_hs   = axiif.arvalid & axiif.arready;
  assign aw_hs   = axiif.awvalid & axiif.awready;
  assign w_hs    = axiif.wvalid & axiif.wready;
  assign wr_both = (have_aw | aw_hs) & (have_w | w_hs);
  // 33-bit compare keeps a window ending at 4 GiB from wrapping
  assign hit = ({1'b0, addr} >= {1'b0, BASE_ADDR}) &&
               ({1'b0, addr} < {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS));
  assign off    = addr - BASE_ADDR;
  assign idx    = off[AW+1:2];
  assign commit = ~rst & (state == WDELAY) & (cnt == '0) & hit;
  assign unused = ^{axiif.arsize, axiif.awsize, axiif.wlast, off};
  always_ff @(posedge clk)
    if (commit)
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      prefer_write <= 1'b0;
      have_aw      <= 1'b0;
      have_w       <= 1'b0;
      cnt          <= '0;
      addr         <= '0;
      wdata        <= '0;
      wstrb        <= '0;
      axiif.rvalid <= 1'b0;
      axiif.bvalid <= 1'b0;
      axiif.rdata  <= '0;
      axiif.rresp  <= 2'b00;
      axiif.bresp  <= 2'b00;
    end else begin
      if (ar_hs) addr <= axiif.araddr;
      if (aw_hs) begin
        addr    <= axiif.awaddr;
        have_aw <= 1'b1;
      end
      if (w_hs) begin
        wdata  <= axiif.wdata;
        wstrb  <= axiif.wstrb;
        have_w <= 1'b1;
      end
      case (state)
        IDLE, WCOLLECT: begin
          if (state == IDLE && rd_req && wr_req) prefer_write <= ~prefer_write;
          if (ar_hs) begin
            cnt   <= CW'(R_LATENCY - 1);
            state <= RDELAY;
          end else if (wr_both) begin
            cnt   <= CW'(W_LATENCY - 1);
            state <= WDELAY;
          end else if (aw_hs | w_hs) state <= WCOLLECT;
        end
        RDELAY:
          if (cnt == '0) begin
            state        <= RRESP;
            axiif.rvalid <= 1'b1;
            axiif.rdata  <= hit ? mem[idx] : '0;
            axiif.rresp  <= hit ? 2'b00 : 2'b11;
          end else cnt <= cnt - 1'b1;
        RRESP:
          if (axiif.rready) begin
            axiif.rvalid <= 1'b0;
            state        <= IDLE;
          end
        WDELAY:
          if (cnt == '0) begin
            state        <= BRESP;
            axiif.bvalid <= 1'b1;
            axiif.bresp  <= hit ? 2'b00 : 2'b11;
            have_aw      <= 1'b0;
            have_w       <= 1'b0;
          end else cnt <= cnt - 1'b1;
        BRESP:
          if (axiif.bready) begin
            axiif.bvalid <= 1'b0;
            state        <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed scoreboard bench for the AXI SRAM responder
module tb_axi_sram_slave;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          RL    = 2;
  localparam int          WL    = 2;
  typedef struct {logic [31:0] data; logic [1:0] resp;} exp_t;
  logic clk, rst;
  int checks, errors;
  exp_t rq[$];
  exp_t bq[$];
  logic [31:0] model [int];
  axi_if bus ();
  axi_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .R_LATENCY(RL), .W_LATENCY(WL)) dut (
    .clk(clk), .rst(rst), .axiif(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic in_rng(input logic [31:0] a);
    return longint'(a) >= longint'(BASE) && longint'(a) < longint'(BASE) + 4 * DEPTH;
  endfunction
  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction
  function automatic exp_t rd_exp(input logic [31:0] a);
    exp_t e;
    e.data = in_rng(a) ? model[widx(a)] : 32'h0;
    e.resp = in_rng(a) ? 2'b00 : 2'b11;
    return e;
  endfunction
  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    bq.push_back('{32'h0, in_rng(a) ? 2'b00 : 2'b11});
    if (in_rng(a)) begin
      w = model.exists(widx(a)) ? model[widx(a)] : 32'hx;
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      model[widx(a)] = w;
    end
  endtask
  task automatic wait_r(input int hold);
    int n;
    exp_t e;
    n = 0;
    while (!bus.rvalid && n < 20) begin tick; n++; end
    chk("r_latency", 32'(n), 32'(RL));
    e = rq.pop_front();
    for (int i = 0; i <= hold; i++) begin
      chk("rvalid", bus.rvalid, 1);
      chk("rdata", bus.rdata, e.data);
      chk("rresp", bus.rresp, e.resp);
      if (i < hold) tick;
    end
    bus.rready = 1;
    tick;
    bus.rready = 0;
    chk("rvalid_clear", bus.rvalid, 0);
  endtask
  task automatic wait_b(input int hold);
    int n;
    exp_t e;
    n = 0;
    while (!bus.bvalid && n < 20) begin tick; n++; end
    chk("b_latency", 32'(n), 32'(WL));
    e = bq.pop_front();
    for (int i = 0; i <= hold; i++) begin
      chk("bvalid", bus.bvalid, 1);
      chk("bresp", bus.bresp, e.resp);
      if (i < hold) tick;
    end
    bus.bready = 1;
    tick;
    bus.bready = 0;
    chk("bvalid_clear", bus.bvalid, 0);
  endtask
  task automatic rd(input logic [31:0] a, input int hold);
    int n;
    bus.araddr  = a;
    bus.arvalid = 1;
    rq.push_back(rd_exp(a));
    #1;
    n = 0;
    while (!bus.arready && n < 20) begin tick; n++; end
    chk("ar_accept", 32'(n < 20), 1);
    tick;
    bus.arvalid = 0;
    wait_r(hold);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int hold);
    int n;
    bus.awaddr  = a;
    bus.wdata   = d;
    bus.wstrb   = s;
    bus.awvalid = 1;
    bus.wvalid  = 1;
    push_wr(a, d, s);
    #1;
    n = 0;
    while (!(bus.awready && bus.wready) && n < 20) begin tick; n++; end
    chk("aw_w_accept", 32'(n < 20), 1);
    tick;
    bus.awvalid = 0;
    bus.wvalid  = 0;
    wait_b(hold);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst = 1;
    bus.araddr = 0; bus.arsize = 3'd2; bus.arvalid = 0; bus.rready = 0;
    bus.awaddr = 0; bus.awsize = 3'd2; bus.awvalid = 0;
    bus.wdata = 0; bus.wstrb = 0; bus.wlast = 1; bus.wvalid = 0; bus.bready = 0;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("rst_arready", bus.arready, 0);
      chk("rst_awready", bus.awready, 0);
      chk("rst_wready", bus.wready, 0);
      chk("rst_rvalid", bus.rvalid, 0);
      chk("rst_bvalid", bus.bvalid, 0);
    end
    rst = 0;
    #1;
    chk("idle_arready", bus.arready, 1);
    chk("idle_awready", bus.awready, 1);
    chk("idle_wready", bus.wready, 1);
    chk("idle_rvalid", bus.rvalid, 0);
    chk("idle_bvalid", bus.bvalid, 0);
    wr(32'h8000_0010, 32'hDEADBEEF, 4'hF, 0);
    rd(32'h8000_0012, 0);
    wr(32'h8000_0020, 32'h11223344, 4'hF, 0);
    wr(32'h8000_0020, 32'h00AA0000, 4'b0100, 2);
    rd(32'h8000_0020, 0);
    // split AW then W three cycles later
    bus.awaddr  = 32'h8000_0040;
    bus.awvalid = 1;
    push_wr(32'h8000_0040, 32'h0BADF00D, 4'hF);
    #1;
    chk("split_awready", bus.awready, 1);
    tick;
    bus.awvalid = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        bus.wdata  = 32'h0BADF00D;
        bus.wstrb  = 4'hF;
        bus.wvalid = 1;
        #1;
      end
      chk("wc_arready", bus.arready, 0);
      chk("wc_awready", bus.awready, 0);
      chk("wc_wready", bus.wready, 1);
      chk("wc_bvalid", bus.bvalid, 0);
      tick;
    end
    bus.wvalid = 0;
    wait_b(0);
    rd(32'h8000_0040, 0);
    // contested: read, then write, then read again
    bus.araddr = 32'h8000_0010; bus.arvalid = 1;
    bus.awaddr = 32'h8000_0030; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1;
    rq.push_back(rd_exp(32'h8000_0010));
    #1;
    chk("c1_arready", bus.arready, 1);
    chk("c1_awready", bus.awready, 0);
    chk("c1_wready", bus.wready, 0);
    tick;
    bus.araddr = 32'h8000_0030;
    wait_r(0);
    chk("c2_arready", bus.arready, 0);
    chk("c2_awready", bus.awready, 1);
    chk("c2_wready", bus.wready, 1);
    push_wr(32'h8000_0030, 32'hCAFEF00D, 4'hF);
    tick;
    bus.awaddr = 32'h8000_0034; bus.wdata = 32'h12345678;
    push_wr(32'h8000_0034, 32'h12345678, 4'hF);
    rq.push_back(rd_exp(32'h8000_0030));
    wait_b(0);
    chk("c3_arready", bus.arready, 1);
    chk("c3_awready", bus.awready, 0);
    chk("c3_wready", bus.wready, 0);
    tick;
    bus.arvalid = 0;
    wait_r(0);
    chk("c4_awready", bus.awready, 1);
    chk("c4_wready", bus.wready, 1);
    tick;
    bus.awvalid = 0; bus.wvalid = 0;
    wait_b(0);
    rd(32'h8000_0034, 0);
    // decode window and back-pressure
    wr(32'h8000_0000, 32'h01020304, 4'hF, 0);
    rd(32'h8000_1000, 5);
    wr(32'h8000_1000, 32'hBAD0BAD0, 4'hF, 3);
    wr(32'h7FFF_FFFC, 32'hBAD1BAD1, 4'hF, 0);
    rd(32'h8000_0000, 0);
    wr(32'h8000_0FFC, 32'hA5A5_5A5A, 4'hF, 0);
    rd(32'h8000_0FFC, 0);
    rd(32'h7FFF_FFFC, 0);
    // reset on the commit edge drops the write
    bus.awaddr = 32'h8000_0010; bus.wdata = 32'h55555555; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1;
    #1;
    chk("mr_accept", bus.awready & bus.wready, 1);
    tick;
    bus.awvalid = 0; bus.wvalid = 0;
    tick;
    rst = 1;
    tick;
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      chk("mr_bvalid", bus.bvalid, 0);
      tick;
    end
    rd(32'h8000_0010, 0);
    chk("rq_drained", 32'(rq.size()), 0);
    chk("bq_drained", 32'(bq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
